// File: rtl/synthesijer_fsub64_arbiter.sv
// Round-robin arbiter sharing one pipelined fsub64 core among NUM_REQ requesters.
// In-flight requester IDs ride a tag FIFO so each result returns to its owner.
module synthesijer_fsub64_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [64*NUM_REQ-1:0]  a_in,
    input  logic [64*NUM_REQ-1:0]  b_in,
    output logic [NUM_REQ-1:0]     ack_out,
    output logic [63:0]            result_out,
    output logic [NUM_REQ-1:0]     valid_out,
    output logic                   busy_out,
    output logic                   err_out,
    output logic [63:0]            core_a,
    output logic [63:0]            core_b,
    output logic                   core_nd,
    input  logic [63:0]            core_result,
    input  logic                   core_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DRN_W = $clog2(LATENCY + 1);

    logic [63:0]        a_arr [NUM_REQ];
    logic [63:0]        b_arr [NUM_REQ];

    logic [TAG_W-1:0]   last_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [DRN_W-1:0]   drain_reg;

    logic [63:0]        core_a_reg;
    logic [63:0]        core_b_reg;
    logic               core_nd_reg;
    logic [63:0]        result_reg;
    logic [NUM_REQ-1:0] valid_reg;
    logic               err_reg;

    logic               drain_active;
    logic               pop;
    logic               full;
    logic               can_grant;
    logic               grant_valid;
    logic [TAG_W-1:0]   grant_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]   = a_in[64*gi +: 64];
            assign b_arr[gi]   = b_in[64*gi +: 64];
            assign ack_out[gi] = grant_valid && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    assign drain_active = (drain_reg != '0);
    assign pop          = reset && core_valid && !drain_active && (count_reg != '0);
    assign full         = (count_reg == CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO can still grant then.
    assign can_grant    = reset && !drain_active && (!full || pop);

    // Walk offsets from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_in[(int'(last_reg) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'((int'(last_reg) + k) % NUM_REQ);
            end
        end
        if (!can_grant) begin
            grant_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_reg    <= TAG_W'(NUM_REQ - 1);
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            drain_reg   <= DRN_W'(LATENCY);
            core_a_reg  <= '0;
            core_b_reg  <= '0;
            core_nd_reg <= 1'b0;
            result_reg  <= '0;
            valid_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (drain_active) begin
                drain_reg <= drain_reg - DRN_W'(1);
            end
            core_nd_reg <= grant_valid;
            if (grant_valid) begin
                core_a_reg <= a_arr[grant_idx];
                core_b_reg <= b_arr[grant_idx];
                last_reg   <= grant_idx;
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            valid_reg <= '0;
            if (pop) begin
                result_reg <= core_result;
                valid_reg  <= NUM_REQ'(1) << tag_mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (core_valid && !drain_active && (count_reg == '0)) begin
                err_reg <= 1'b1;
            end
            case ({grant_valid, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && grant_valid) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    assign core_a     = core_a_reg;
    assign core_b     = core_b_reg;
    assign core_nd    = core_nd_reg;
    assign result_out = result_reg;
    assign valid_out  = valid_reg;
    assign err_out    = err_reg;
    assign busy_out   = (count_reg != '0);

endmodule

// File: doc/synthesijer_fsub64_arbiter.md
# synthesijer_fsub64_arbiter

Round-robin arbiter that shares one pipelined 64-bit floating-point subtract core (the fsub64 wrapper: a, b, nd in; result, valid out; fixed latency, no backpressure) among NUM_REQ requesters. It grants at most one request per cycle, drives the core's operand and nd inputs from registers, and tracks each in-flight operation's requester ID in a tag FIFO. Each returning result is steered to its owner as a one-cycle valid pulse. It sits between generated datapath units and the single instantiated fsub64 core.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- TAG_W, 2, requester-index width, ≥ clog2(NUM_REQ)
- DEPTH, 16, tag FIFO depth and max in-flight ops; power of two, ≥ core latency
- LATENCY, 12, core latency, nd to valid, in cycles; used only for post-reset drain

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_in  in  NUM_REQ  per-requester request, held with operands until ack
- a_in  in  64*NUM_REQ  minuend, requester i at [64i+63:64i]
- b_in  in  64*NUM_REQ  subtrahend, same packing
- ack_out  out  NUM_REQ  one-hot, combinational; request accepted this cycle
- result_out  out  64  registered result, shared by all requesters
- valid_out  out  NUM_REQ  one-hot, one-cycle pulse qualifying result_out
- busy_out  out  1  in-flight count ≠ 0
- err_out  out  1  sticky; core_valid arrived with empty tag FIFO
- core_a  out  64  to core a
- core_b  out  64  to core b
- core_nd  out  1  to core nd
- core_result  in  64  from core result
- core_valid  in  1  from core valid

## Operation
- Grant: when in-flight count < DEPTH and any req_in bit is set, grant the first set bit scanning upward from last+1, modulo NUM_REQ. ack_out = one-hot grant, combinational.
- last: register updated to the granted index on each grant; reset value NUM_REQ-1, so requester 0 has first priority.
- Issue: on a grant, core_a/core_b load the granted requester's operands, core_nd ← 1, and the grant index is pushed into the tag FIFO. Without a grant, core_nd ← 0 and core_a/core_b hold their values.
- Requester rule: drop req_in, or present new operands, in the cycle after ack. A req_in still high after ack is a new request.
- Return: on core_valid, result_out ← core_result and valid_out ← one-hot(FIFO head); the head is popped. Otherwise valid_out ← 0 and result_out holds.
- Count: in-flight count increments on push and decrements on pop. A simultaneous push and pop leaves it unchanged. When full (count = DEPTH), no grants are made and ack_out = 0.
- FIFO pointers are TAG_W-independent, log2(DEPTH) bits wide, and wrap naturally.
- Error: core_valid with count = 0 sets err_out, is otherwise ignored, and produces no valid_out. Suppressed during drain.
- Drain: after reset releases, a counter suppresses all core_valid handling, including error checks, for LATENCY cycles. This discards results of operations issued before reset.
- Reset (reset = 0 at a clk edge): core_nd, core_a, core_b, result_out, valid_out, err_out, the FIFO pointers and the count all ← 0; last ← NUM_REQ-1; drain counter ← LATENCY. ack_out is forced to 0 while reset = 0 and during drain. A mid-operation reset abandons all in-flight operations; no valid_out is issued for them.

## Timing
- Request seen in cycle t with a grant: ack_out high in t; core_nd high in t+1; core_valid in t+1+LATENCY; valid_out and result_out in t+2+LATENCY.
- Total accept-to-result latency is LATENCY+2 cycles.
- Throughput is one grant per cycle; back-to-back grants may go to the same requester only if no other requester is requesting.
- Results return in issue order, so the FIFO order equals the grant order.

## Test plan
- Single request: req_in=0001, a=0x4008000000000000 (3.0), b=0x3FF0000000000000 (1.0). Required: ack_out[0] in the same cycle; valid_out=0001 with result_out=0x4000000000000000 (2.0) exactly LATENCY+2 cycles later.
- All four requesters assert req_in together and hold it until their ack. Required: acks in order 0,1,2,3 on consecutive cycles; valid_out pulses 0001, 0010, 0100, 1000 on consecutive cycles, each with the matching difference.
- Fairness: requester 1 holds req_in continuously while requester 2 toggles. Required: when both are requesting, grants alternate 1,2,1,2; requester 2 is never skipped twice in a row.
- Full: a stub core with latency > DEPTH and all requesters continuously requesting. Required: exactly DEPTH grants, then ack_out=0 until the first core_valid; the next grant comes in the same cycle as that pop.
- Reset mid-flight: issue 5 ops, then pulse reset low for 1 cycle. Required: all outputs take reset values; no valid_out for those ops; err_out stays 0 while late core_valid pulses arrive within LATENCY cycles; a new request afterwards completes normally.
- Spurious core_valid when idle and past drain. Required: err_out rises the next cycle and stays high until reset; valid_out stays 0.
